// File: rtl/window_cache.sv
// 3x3 sliding-window cache over a raster pixel stream using two line buffers.
// Define WINDOW_CACHE_CNT_EN to add the saturating win_count output.
module window_cache #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  output logic [23:0] cache_out [0:2],
  output logic        win_valid,
  output logic        frame_done,
  output logic        busy
`ifdef WINDOW_CACHE_CNT_EN
  ,
  output logic [31:0] win_count
`endif
);

  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);

  logic [ColW-1:0] col_q, col_d, col_cur;
  logic [RowW-1:0] row_q, row_d, row_cur;
  logic [23:0]     sr_q [3];
  logic [23:0]     sr_d [3];
  logic            win_valid_q, win_valid_d;
  logic            frame_done_q, frame_done_d;
  logic            busy_q, busy_d;
  logic [7:0]      top, mid;
  logic            last_col, last_row;

  // Line buffers hold no reset; stale contents are masked by the row/col window gating.
  logic [7:0] lb0_mem [IMG_W];
  logic [7:0] lb1_mem [IMG_W];

  always_comb begin
    // A start in the same cycle as a pixel makes that pixel (0,0) of the new frame.
    col_cur  = start ? '0 : col_q;
    row_cur  = start ? '0 : row_q;
    top      = lb1_mem[col_cur];
    mid      = lb0_mem[col_cur];
    last_col = (col_cur == ColLast);
    last_row = (row_cur == RowLast);

    col_d        = col_cur;
    row_d        = row_cur;
    sr_d         = sr_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = busy_q;

    if (start) begin
      busy_d = 1'b1;
    end
    if (pix_valid) begin
      busy_d      = 1'b1;
      col_d       = last_col ? '0 : col_cur + ColW'(1);
      row_d       = last_col ? (last_row ? '0 : row_cur + RowW'(1)) : row_cur;
      sr_d[0]     = {top,    sr_q[0][23:8]};
      sr_d[1]     = {mid,    sr_q[1][23:8]};
      sr_d[2]     = {pix_in, sr_q[2][23:8]};
      win_valid_d = (row_cur >= RowW'(2)) && (col_cur >= ColW'(2));
      if (last_col && last_row) begin
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      sr_q[0]      <= '0;
      sr_q[1]      <= '0;
      sr_q[2]      <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      sr_q         <= sr_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  // Read-before-write: the reads above see the old entries at col_cur.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb1_mem[col_cur] <= mid;
      lb0_mem[col_cur] <= pix_in;
    end
  end

  assign cache_out[0] = sr_q[0];
  assign cache_out[1] = sr_q[1];
  assign cache_out[2] = sr_q[2];
  assign win_valid    = win_valid_q;
  assign frame_done   = frame_done_q;
  assign busy         = busy_q;

`ifdef WINDOW_CACHE_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Tracks win_valid_d so the count is current in the same cycle as the pulse.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (win_valid_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign win_count = cnt_q;
`endif

endmodule

// File: tb/tb_window_cache.sv
// Self-checking bench for window_cache (IMG_W=IMG_H=4): image-based reference model,
// directed frames with literal pins, then randomized valid/start/pixel stimulus.
module tb_window_cache;
  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        pix_valid;
  logic [7:0]  pix_in;
  logic [23:0] cache_out [0:2];
  logic        win_valid;
  logic        frame_done;
  logic        busy;
`ifdef WINDOW_CACHE_CNT_EN
  logic [31:0] win_count;
`endif

  window_cache #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .cache_out  (cache_out),
    .win_valid  (win_valid),
    .frame_done (frame_done),
    .busy       (busy)
`ifdef WINDOW_CACHE_CNT_EN
    ,
    .win_count  (win_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pixels of the current frame stored by (row, col).
  logic [7:0]  img [H][W];
  int          mr = 0;
  int          mc = 0;
  bit          mbusy = 1'b0;
  bit          exp_valid = 1'b0, exp_done = 1'b0, exp_busy = 1'b0;
  logic [23:0] exp_win [3];
  bit          p_valid, p_done;
  logic [23:0] p_win [3];
  longint      exp_cnt = 0;

  int          seen_win, seen_done;
  logic [23:0] first_win [3];
  logic [23:0] last_win [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic compare();
    chk("win_valid", {31'd0, win_valid}, {31'd0, exp_valid});
    chk("frame_done", {31'd0, frame_done}, {31'd0, exp_done});
    chk("busy", {31'd0, busy}, {31'd0, exp_busy});
    if (exp_valid) begin
      for (int k = 0; k < 3; k++) chk($sformatf("cache_out[%0d]", k), {8'd0, cache_out[k]},
                                      {8'd0, exp_win[k]});
    end
`ifdef WINDOW_CACHE_CNT_EN
    chk("win_count", win_count, exp_cnt[31:0]);
`endif
    if (win_valid) begin
      for (int k = 0; k < 3; k++) begin
        if (seen_win == 0) first_win[k] = cache_out[k];
        last_win[k] = cache_out[k];
      end
      seen_win++;
    end
    if (frame_done) seen_done++;
  endtask

  task automatic step(input bit st, input bit pv, input logic [7:0] px);
    start     = st;
    pix_valid = pv;
    pix_in    = px;
    if (st) begin
      mr = 0; mc = 0; mbusy = 1'b1; exp_cnt = 0;
    end
    p_valid = 1'b0;
    p_done  = 1'b0;
    if (pv) begin
      mbusy = 1'b1;
      img[mr][mc] = px;
      if (mr >= 2 && mc >= 2) begin
        p_valid = 1'b1;
        for (int k = 0; k < 3; k++)
          p_win[k] = {img[mr-2+k][mc], img[mr-2+k][mc-1], img[mr-2+k][mc-2]};
      end
      if (mr == H - 1 && mc == W - 1) begin
        p_done = 1'b1;
        mbusy  = 1'b0;
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr++;
        if (mr == H) mr = 0;
      end
    end
    @(posedge clk);
    exp_valid = p_valid;
    exp_done  = p_done;
    exp_busy  = mbusy;
    if (p_valid) begin
      exp_win = p_win;
      if (exp_cnt < 64'hFFFF_FFFF) exp_cnt++;
    end
    @(negedge clk);
    compare();
  endtask

  task automatic stream_frame(input int gap, input bit st_first);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        step(st_first && r == 0 && c == 0, 1'b1, 8'(r * 16 + c));
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 8'($urandom));
      end
    end
  endtask

  task automatic clear_seen();
    seen_win  = 0;
    seen_done = 0;
  endtask

  task automatic pin_frame(input string tag);
    chk({tag, "_first0"}, {8'd0, first_win[0]}, 32'h020100);
    chk({tag, "_first1"}, {8'd0, first_win[1]}, 32'h121110);
    chk({tag, "_first2"}, {8'd0, first_win[2]}, 32'h222120);
    chk({tag, "_last2"}, {8'd0, last_win[2]}, 32'h333231);
    chk({tag, "_nwin"}, seen_win, 4);
    chk({tag, "_ndone"}, seen_done, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    pix_valid = 1'b0;
    pix_in    = 8'd0;
    for (int k = 0; k < 3; k++) exp_win[k] = '0;
    clear_seen();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) chk("rst_cache", {8'd0, cache_out[k]}, 32'd0);
    compare();
    rst_n = 1'b1;

    // Plain frame after a separate start cycle.
    clear_seen();
    step(1'b1, 1'b0, 8'd0);
    stream_frame(0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 8'd0);
    pin_frame("plain");
`ifdef WINDOW_CACHE_CNT_EN
    chk("cnt_after_frame", win_count, 32'd4);
    step(1'b1, 1'b0, 8'd0);
    chk("cnt_after_start", win_count, 32'd0);
`endif

    // 3-cycle gaps, start coincident with the first pixel.
    clear_seen();
    stream_frame(3, 1'b1);
    repeat (2) step(1'b0, 1'b0, 8'd0);
    pin_frame("gaps");

    // Abort after pixel 0x21, then a fresh frame.
    clear_seen();
    step(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'((i / W) * 16 + (i % W)));
    chk("abort_nowin", seen_win, 0);
    stream_frame(0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 8'd0);
    pin_frame("abort");

    // Asynchronous reset mid-line.
    step(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 8'((i / W) * 16 + (i % W)));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_win_valid", {31'd0, win_valid}, 32'd0);
    chk("arst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 3; k++) chk("arst_cache", {8'd0, cache_out[k]}, 32'd0);
    mr = 0; mc = 0; mbusy = 1'b0; exp_cnt = 0;
    exp_valid = 1'b0; exp_done = 1'b0; exp_busy = 1'b0;
    @(negedge clk);
    compare();
    rst_n = 1'b1;
    clear_seen();
    step(1'b1, 1'b0, 8'd0);
    stream_frame(0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 8'd0);
    pin_frame("post_rst");

    // Randomized valid gaps, occasional restarts, random pixel values.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70, 8'($urandom));
    end
    repeat (2) step(1'b0, 1'b0, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
